// File: rtl/switch_scan_ctrl_pkg.sv
// Shared constants for the DIP switch scan controller: register window map,
// ctrl/status bit positions and the default debounce period.
package switch_scan_ctrl_pkg;

  localparam int DEBOUNCE_CYCLES_DEF = 20000;

  localparam logic [2:0] ADDR_STABLE_LO = 3'd0;
  localparam logic [2:0] ADDR_STABLE_HI = 3'd1;
  localparam logic [2:0] ADDR_FLAGS_LO  = 3'd2;
  localparam logic [2:0] ADDR_FLAGS_HI  = 3'd3;
  localparam logic [2:0] ADDR_CTRL      = 3'd4;
  localparam logic [2:0] ADDR_STATUS    = 3'd5;
  localparam logic [2:0] ADDR_MASK_LO   = 3'd6;
  localparam logic [2:0] ADDR_MASK_HI   = 3'd7;

  localparam int CTRL_IE      = 0;
  localparam int CTRL_SCAN_EN = 1;

  localparam int STAT_TICK_SEEN = 0;
  localparam int STAT_SCAN_EN   = 1;
  localparam int STAT_PENDING   = 2;

endpackage

// File: rtl/switch_scan_ctrl_scan_tick_gen.sv
// Enable-gated wrapping counter that emits a one-cycle sample tick every
// DEBOUNCE_CYCLES enabled cycles; the count holds while disabled.
module scan_tick_gen
  import switch_scan_ctrl_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter int CNT_W           = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  output logic tick
);

  localparam logic [CNT_W-1:0] LAST_COUNT = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] ONE_COUNT  = CNT_W'(32'd1);

  logic [CNT_W-1:0] count_r;

  assign tick = en && (count_r == LAST_COUNT);

  // Tick counter: wraps on the tick, frozen while scanning is disabled.
  always_ff @(posedge clk) begin
    if (reset) begin
      count_r <= '0;
    end else if (tick) begin
      count_r <= '0;
    end else if (en) begin
      count_r <= count_r + ONE_COUNT;
    end else begin
      count_r <= count_r;
    end
  end

endmodule

// File: rtl/switch_scan_ctrl.sv
// DIP switch scan controller: tick-sampled two-sample debounce of 64 active-low
// switches, sticky change flags and a level IRQ. Optional SWITCH_SCAN_MASK_EN adds an IRQ mask.
module switch_scan_ctrl
  import switch_scan_ctrl_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter int CNT_W           = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  dip_switch7,
  input  logic [7:0]  dip_switch6,
  input  logic [7:0]  dip_switch5,
  input  logic [7:0]  dip_switch4,
  input  logic [7:0]  dip_switch3,
  input  logic [7:0]  dip_switch2,
  input  logic [7:0]  dip_switch1,
  input  logic [7:0]  dip_switch0,
  input  logic [2:0]  Addr,
  input  logic        WE,
  input  logic [31:0] WD,
  output logic [31:0] RD,
  output logic        IRQ
);

  logic [63:0] sample_s;
  logic [63:0] prev_sample_r;
  logic [63:0] stable_r;
  logic [63:0] flags_r;
  logic [63:0] set_s;
  logic [63:0] clr_s;
  logic [63:0] flags_next_s;
  logic [63:0] mask_s;
  logic [1:0]  ctrl_r;
  logic [31:0] status_s;
  logic        tick_s;
  logic        settled_s;
  logic        pending_s;
  logic        tick_seen_r;
  logic        irq_r;

  scan_tick_gen #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
    .CNT_W           (CNT_W)
  ) u_tick (
    .clk   (clk),
    .reset (reset),
    .en    (ctrl_r[CTRL_SCAN_EN]),
    .tick  (tick_s)
  );

  assign sample_s  = ~{dip_switch7, dip_switch6, dip_switch5, dip_switch4,
                       dip_switch3, dip_switch2, dip_switch1, dip_switch0};
  // Two identical consecutive tick samples count as settled.
  assign settled_s = tick_s && (sample_s == prev_sample_r);
  assign set_s     = settled_s ? (sample_s ^ stable_r) : 64'd0;

  // Write-1-to-clear mask for the flag halves.
  always_comb begin
    clr_s = 64'd0;
    if (WE && (Addr == ADDR_FLAGS_LO)) begin
      clr_s = {32'd0, WD};
    end else if (WE && (Addr == ADDR_FLAGS_HI)) begin
      clr_s = {WD, 32'd0};
    end else begin
      clr_s = 64'd0;
    end
  end

  assign flags_next_s = (flags_r & ~clr_s) | set_s;

`ifdef SWITCH_SCAN_MASK_EN
  logic [63:0] mask_r;

  // Interrupt mask register, enables every bit out of reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      mask_r <= {64{1'b1}};
    end else if (WE && (Addr == ADDR_MASK_LO)) begin
      mask_r[31:0] <= WD;
    end else if (WE && (Addr == ADDR_MASK_HI)) begin
      mask_r[63:32] <= WD;
    end else begin
      mask_r <= mask_r;
    end
  end

  assign mask_s = mask_r;
`else
  assign mask_s = {64{1'b1}};
`endif

  assign pending_s = |(flags_r & mask_s);

  // Status word assembly.
  always_comb begin
    status_s                 = 32'd0;
    status_s[STAT_TICK_SEEN] = tick_seen_r;
    status_s[STAT_SCAN_EN]   = ctrl_r[CTRL_SCAN_EN];
    status_s[STAT_PENDING]   = pending_s;
  end

  // Register window read mux.
  always_comb begin
    RD = 32'd0;
    case (Addr)
      ADDR_STABLE_LO: RD = stable_r[31:0];
      ADDR_STABLE_HI: RD = stable_r[63:32];
      ADDR_FLAGS_LO:  RD = flags_r[31:0];
      ADDR_FLAGS_HI:  RD = flags_r[63:32];
      ADDR_CTRL:      RD = {30'd0, ctrl_r};
      ADDR_STATUS:    RD = status_s;
`ifdef SWITCH_SCAN_MASK_EN
      ADDR_MASK_LO:   RD = mask_s[31:0];
      ADDR_MASK_HI:   RD = mask_s[63:32];
`else
      ADDR_MASK_LO,
      ADDR_MASK_HI:   RD = 32'd0;
`endif
      default:        RD = 32'd0;
    endcase
  end

  // Debounce state, flags, control and the registered interrupt.
  always_ff @(posedge clk) begin
    if (reset) begin
      prev_sample_r <= 64'd0;
      stable_r      <= 64'd0;
      flags_r       <= 64'd0;
      ctrl_r        <= 2'b00;
      tick_seen_r   <= 1'b0;
      irq_r         <= 1'b0;
    end else begin
      if (tick_s) begin
        prev_sample_r <= sample_s;
      end
      if (settled_s) begin
        stable_r <= sample_s;
      end
      flags_r <= flags_next_s;
      if (WE && (Addr == ADDR_CTRL)) begin
        ctrl_r <= WD[1:0];
      end
      if (tick_s) begin
        tick_seen_r <= 1'b1;
      end else if (WE && (Addr == ADDR_STATUS)) begin
        tick_seen_r <= 1'b0;
      end
      irq_r <= ctrl_r[CTRL_IE] & pending_s;
    end
  end

  assign IRQ = irq_r;

endmodule

// File: tb/tb_switch_scan_ctrl.sv
// Self-checking bench for switch_scan_ctrl (DEBOUNCE_CYCLES=4): reset/readback tables,
// directed debounce/W1C/bounce/freeze/mask sequences and randomized traffic vs a reference model.
module tb_switch_scan_ctrl;

  localparam int DC = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic [63:0] sw_raw;
  logic [2:0]  Addr;
  logic        WE;
  logic [31:0] WD;
  logic [31:0] RD;
  logic        IRQ;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  switch_scan_ctrl #(.DEBOUNCE_CYCLES(DC), .CNT_W(16)) dut (
    .clk         (clk),
    .reset       (reset),
    .dip_switch7 (sw_raw[63:56]),
    .dip_switch6 (sw_raw[55:48]),
    .dip_switch5 (sw_raw[47:40]),
    .dip_switch4 (sw_raw[39:32]),
    .dip_switch3 (sw_raw[31:24]),
    .dip_switch2 (sw_raw[23:16]),
    .dip_switch1 (sw_raw[15:8]),
    .dip_switch0 (sw_raw[7:0]),
    .Addr        (Addr),
    .WE          (WE),
    .WD          (WD),
    .RD          (RD),
    .IRQ         (IRQ)
  );

  // Reference model state
  logic [63:0] m_prev, m_stable, m_flags, m_mask;
  logic [1:0]  m_ctrl;
  logic        m_tseen, m_irq;
  int          m_en_cycles = 0;
  int          m_ticks = 0;

  function automatic logic m_tick_now();
    return m_ctrl[1] && ((m_en_cycles % DC) == DC - 1);
  endfunction

  task automatic model_edge();
    logic [63:0] s, clr;
    logic tk, eq;
    if (reset) begin
      m_prev = 64'd0; m_stable = 64'd0; m_flags = 64'd0; m_ctrl = 2'b00;
      m_tseen = 1'b0; m_irq = 1'b0; m_en_cycles = 0;
      m_mask = {64{1'b1}};
      return;
    end
    s   = ~sw_raw;
    tk  = m_tick_now();
    eq  = tk && (s == m_prev);
    clr = 64'd0;
    if (WE && Addr == 3'd2) clr = {32'd0, WD};
    if (WE && Addr == 3'd3) clr = {WD, 32'd0};
    m_irq   = m_ctrl[0] && ((m_flags & m_mask) != 64'd0);
    m_flags = (m_flags & ~clr) | (eq ? (s ^ m_stable) : 64'd0);
    if (eq) m_stable = s;
    if (tk) m_prev = s;
    if (tk) m_tseen = 1'b1;
    else if (WE && Addr == 3'd5) m_tseen = 1'b0;
`ifdef SWITCH_SCAN_MASK_EN
    if (WE && Addr == 3'd6) m_mask[31:0] = WD;
    if (WE && Addr == 3'd7) m_mask[63:32] = WD;
`endif
    if (m_ctrl[1]) m_en_cycles++;
    if (WE && Addr == 3'd4) m_ctrl = WD[1:0];
    if (tk) m_ticks++;
  endtask

  function automatic logic [31:0] m_read(input logic [2:0] a);
    logic pend;
    pend = (m_flags & m_mask) != 64'd0;
    case (a)
      3'd0: return m_stable[31:0];
      3'd1: return m_stable[63:32];
      3'd2: return m_flags[31:0];
      3'd3: return m_flags[63:32];
      3'd4: return {30'd0, m_ctrl};
      3'd5: return {29'd0, pend, m_ctrl[1], m_tseen};
`ifdef SWITCH_SCAN_MASK_EN
      3'd6: return m_mask[31:0];
      3'd7: return m_mask[63:32];
`endif
      default: return 32'd0;
    endcase
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    chk("rd_model", RD, m_read(Addr));
    chk("irq_model", {31'd0, IRQ}, {31'd0, m_irq});
  endtask

  task automatic wr(input logic [2:0] a, input logic [31:0] d);
    Addr = a; WE = 1'b1; WD = d;
    step();
    WE = 1'b0;
  endtask

  task automatic rd_chk(input string name, input logic [2:0] a, input logic [31:0] exp);
    Addr = a;
    #1;
    chk(name, RD, exp);
  endtask

  task automatic wait_ticks(input int n);
    int target;
    int budget;
    target = m_ticks + n;
    budget = 0;
    while (m_ticks < target && budget < 200) begin
      step();
      budget++;
    end
    if (m_ticks < target) chk("tick_timeout", 32'(m_ticks), 32'(target));
  endtask

  task automatic wait_tick_next();
    int budget;
    budget = 0;
    while (!m_tick_now() && budget < 50) begin
      step();
      budget++;
    end
    if (!m_tick_now()) chk("tick_next_timeout", 32'd0, 32'd1);
  endtask

  typedef struct {
    logic [2:0]  addr;
    logic [31:0] exp;
  } rd_vec_t;

  rd_vec_t reset_tab[8];
  rd_vec_t ctrl_tab[6];

  initial begin
    for (int i = 0; i < 8; i++) begin
      reset_tab[i].addr = 3'(i);
      reset_tab[i].exp  = 32'd0;
    end
`ifdef SWITCH_SCAN_MASK_EN
    reset_tab[6].exp = 32'hFFFF_FFFF;
    reset_tab[7].exp = 32'hFFFF_FFFF;
`endif
    for (int i = 0; i < 6; i++) begin
      ctrl_tab[i].addr = 3'(i);
      ctrl_tab[i].exp  = 32'd0;
    end
    ctrl_tab[4].exp = 32'd3;
    ctrl_tab[5].exp = 32'd2;

    reset = 1'b1; sw_raw = {64{1'b1}}; Addr = 3'd0; WE = 1'b0; WD = 32'd0;
    step(); step();
    reset = 1'b0;
    for (int i = 0; i < 8; i++) rd_chk("reset_read", reset_tab[i].addr, reset_tab[i].exp);

    wr(3'd4, 32'd3);
    for (int i = 0; i < 6; i++) rd_chk("ctrl_read", ctrl_tab[i].addr, ctrl_tab[i].exp);
    wait_ticks(1);
    rd_chk("status_first_tick", 3'd5, 32'd3);
    rd_chk("flags_lo_idle", 3'd2, 32'd0);

    // Single switch closes and settles
    sw_raw[7:0] = 8'hFE;
    wait_ticks(1);
    rd_chk("stable_after_1tick", 3'd0, 32'd0);
    wait_ticks(1);
    rd_chk("stable_after_2tick", 3'd0, 32'd1);
    rd_chk("flags_set", 3'd2, 32'd1);
    chk("irq_not_yet", {31'd0, IRQ}, 32'd0);
    step();
    chk("irq_raised", {31'd0, IRQ}, 32'd1);
    rd_chk("status_pending", 3'd5, 32'd7);

    // W1C and IRQ drop
    wr(3'd2, 32'd1);
    rd_chk("flags_cleared", 3'd2, 32'd0);
    chk("irq_lag", {31'd0, IRQ}, 32'd1);
    step();
    chk("irq_dropped", {31'd0, IRQ}, 32'd0);

    // Set wins over simultaneous W1C
    sw_raw[7:0] = 8'hFF;
    wait_ticks(1);
    wait_tick_next();
    Addr = 3'd2; WE = 1'b1; WD = 32'd1;
    step();
    WE = 1'b0;
    rd_chk("set_wins", 3'd2, 32'd1);
    rd_chk("stable_released", 3'd0, 32'd0);
    wr(3'd2, 32'd1);
    step();
    chk("irq_after_clear", {31'd0, IRQ}, 32'd0);

    // Bounce shorter than a tick period on bit 40
    wait_ticks(1);
    sw_raw[40] = 1'b0;
    step(); step(); step();
    sw_raw[40] = 1'b1;
    wait_ticks(2);
    rd_chk("bounce_stable_hi", 3'd1, 32'd0);
    rd_chk("bounce_flags_hi", 3'd3, 32'd0);
    chk("bounce_irq", {31'd0, IRQ}, 32'd0);

    // Scanning disabled freezes the debounce
    wr(3'd4, 32'd1);
    wr(3'd5, 32'd0);
    sw_raw[7:0] = 8'h00;
    for (int i = 0; i < 20; i++) step();
    rd_chk("frozen_status", 3'd5, 32'd0);
    rd_chk("frozen_stable", 3'd0, 32'd0);
    wr(3'd4, 32'd3);
    wait_ticks(1);
    rd_chk("resume_1tick", 3'd0, 32'd0);
    wait_ticks(1);
    rd_chk("resume_2tick", 3'd0, 32'h0000_00FF);
    rd_chk("resume_flags", 3'd2, 32'h0000_00FF);

`ifdef SWITCH_SCAN_MASK_EN
    wr(3'd2, 32'h0000_00FF);
    wr(3'd6, 32'd0);
    sw_raw[7:0] = 8'h08;
    wait_ticks(2);
    rd_chk("masked_flag", 3'd2, 32'd8);
    step();
    chk("masked_irq", {31'd0, IRQ}, 32'd0);
    wr(3'd6, 32'd8);
    step();
    chk("unmasked_irq", {31'd0, IRQ}, 32'd1);
`endif

    // Randomized traffic against the model
    reset = 1'b1;
    step(); step();
    reset = 1'b0;
    sw_raw = {64{1'b1}};
    wr(3'd4, 32'd3);
    for (int i = 0; i < 3000; i++) begin
      Addr = 3'($urandom_range(0, 7));
      WE   = ($urandom_range(0, 9) == 0);
      WD   = $urandom;
      if (Addr == 3'd4) WD[1] = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 15) == 0) begin
        int g;
        logic [7:0] v;
        g = $urandom_range(0, 7);
        v = 8'($urandom);
        sw_raw[g*8 +: 8] = v;
      end
      if ($urandom_range(0, 31) == 0) sw_raw[$urandom_range(0, 63)] ^= 1'b1;
      step();
    end
    WE = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
